// File: rtl/rssb_seq_control.sv
`default_nettype none
// ============================================================================
// Module   : rssb_seq_control
// Purpose  : Instruction sequencer for an RSSB (reverse-subtract, skip if
//            borrow) core. It steps each instruction through its phases:
//            fetch the operand address, read the operand, write the result
//            back, then update pc. Each memory access waits for an
//            acknowledge. The block also provides start/halt control,
//            single-step pausing, a per-access timeout with a sticky error,
//            and a count of retired instructions.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   leave IDLE/HALT and begin fetching
//   halt_req     in   stop at the next instruction boundary
//   step_mode    in   pause after every instruction
//   step         in   run one more instruction from PAUSE
//   neg          in   datapath borrow flag, used in UPDATE
//   mem_ack      in   memory completes the current access
//   mem_req      out  memory access request
//   mem_we       out  1 = write access
//   sel_mem      out  memory address select (0 = pc, 1 = op1)
//   sel_pc       out  pc mux select (0 = pc+1, 1 = pc+2)
//   write_op1    out  load op1 from read data
//   write_acc    out  load acc with rdata - acc
//   write_mem    out  drive acc onto write data
//   write_pc     out  load pc from the pc mux
//   busy         out  executing an instruction
//   halted       out  in HALT
//   error        out  access timed out (sticky until rst)
//   instr_count  out  retired instruction count (wraps)
// ============================================================================
module rssb_seq_control #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt_req,
   input  logic             step_mode,
   input  logic             step,
   input  logic             neg,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic             sel_mem,
   output logic             sel_pc,
   output logic             write_op1,
   output logic             write_acc,
   output logic             write_mem,
   output logic             write_pc,
   output logic             busy,
   output logic             halted,
   output logic             error,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_READ   = 3'd2,
      S_WRITE  = 3'd3,
      S_UPDATE = 3'd4,
      S_PAUSE  = 3'd5,
      S_HALT   = 3'd6,
      S_ERROR  = 3'd7
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             access_w;
   logic             timeout_w;

   assign access_w    = (state_q == S_FETCH) || (state_q == S_READ) || (state_q == S_WRITE);
   assign instr_count = count_q;

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

         logic [WAIT_W-1:0] wait_q, wait_d;

         // Every ack leaves its access state, so clearing on ack (or on any
         // non-access state) gives a fresh count on entry to each access.
         always_comb begin
            wait_d = '0;
            if (access_w && !mem_ack) begin
               wait_d = wait_q + 1'b1;
            end
         end

         // Fires on the cycle the count would reach the limit with no ack;
         // an ack on that same cycle completes the access instead.
         assign timeout_w = access_w && !mem_ack &&
                            (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

         always_ff @(posedge clk) begin
            if (rst) begin
               wait_q <= '0;
            end else begin
               wait_q <= wait_d;
            end
         end
      end else begin : g_no_timeout
         assign timeout_w = 1'b0;
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      sel_mem   = 1'b0;
      sel_pc    = 1'b0;
      write_op1 = 1'b0;
      write_acc = 1'b0;
      write_mem = 1'b0;
      write_pc  = 1'b0;
      busy      = 1'b0;
      halted    = 1'b0;
      error     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            busy    = 1'b1;
            if (mem_ack) begin
               write_op1 = 1'b1;
               state_d   = S_READ;
            end else if (timeout_w) begin
               state_d = S_ERROR;
            end
         end
         S_READ: begin
            mem_req = 1'b1;
            sel_mem = 1'b1;
            busy    = 1'b1;
            if (mem_ack) begin
               write_acc = 1'b1;
               state_d   = S_WRITE;
            end else if (timeout_w) begin
               state_d = S_ERROR;
            end
         end
         S_WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            sel_mem   = 1'b1;
            write_mem = 1'b1;
            busy      = 1'b1;
            if (mem_ack) begin
               state_d = S_UPDATE;
            end else if (timeout_w) begin
               state_d = S_ERROR;
            end
         end
         S_UPDATE: begin
            write_pc = 1'b1;
            sel_pc   = neg;
            busy     = 1'b1;
            count_d  = count_q + 1'b1;
            if (halt_req) begin
               state_d = S_HALT;
            end else if (step_mode) begin
               state_d = S_PAUSE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_PAUSE: begin
            if (halt_req) begin
               state_d = S_HALT;
            end else if (step) begin
               state_d = S_FETCH;
            end
         end
         S_HALT: begin
            halted = 1'b1;
            if (start) state_d = S_FETCH;
         end
         S_ERROR: begin
            error = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rssb_seq_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rssb_seq_control
// Purpose  : Self-checking bench for rssb_seq_control (TIMEOUT_CYCLES=16,
//            CNT_W=4). Each retired instruction pushes its expected sel_pc
//            and post-update count into a queue; entries are popped and
//            compared when the DUT reaches UPDATE.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rssb_seq_control;

   localparam int CW = 4;

   // Output vector order: mem_req, mem_we, sel_mem, sel_pc, write_op1,
   // write_acc, write_mem, write_pc, busy, halted, error
   localparam logic [10:0] E_IDLE      = 11'b00000000000;
   localparam logic [10:0] E_FETCH     = 11'b10000000100;
   localparam logic [10:0] E_FETCH_ACK = 11'b10001000100;
   localparam logic [10:0] E_READ      = 11'b10100000100;
   localparam logic [10:0] E_READ_ACK  = 11'b10100100100;
   localparam logic [10:0] E_WRITE     = 11'b11100010100;
   localparam logic [10:0] E_UPDATE    = 11'b00000001100;
   localparam logic [10:0] E_HALT      = 11'b00000000010;
   localparam logic [10:0] E_ERROR     = 11'b00000000001;

   logic clk = 1'b0;
   logic rst, start, halt_req, step_mode, step, neg, mem_ack;
   logic mem_req, mem_we, sel_mem, sel_pc, write_op1, write_acc, write_mem, write_pc;
   logic busy, halted, error;
   logic [CW-1:0] instr_count;
   logic [10:0]   obs;

   typedef struct packed {
      logic          sel;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t          exp_q[$];
   logic [CW-1:0] exp_cnt;
   int            errors = 0;
   int            checks = 0;

   rssb_seq_control #(.TIMEOUT_CYCLES(16), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
      .step_mode(step_mode), .step(step), .neg(neg), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_we(mem_we), .sel_mem(sel_mem), .sel_pc(sel_pc),
      .write_op1(write_op1), .write_acc(write_acc), .write_mem(write_mem),
      .write_pc(write_pc), .busy(busy), .halted(halted), .error(error),
      .instr_count(instr_count)
   );

   assign obs = {mem_req, mem_we, sel_mem, sel_pc, write_op1, write_acc,
                 write_mem, write_pc, busy, halted, error};

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Entered at a negedge with the DUT in FETCH; returns at the negedge
   // following UPDATE. Waits are cycles without ack before the ack cycle.
   task automatic run_instr(input int fw, input int rw, input int ww, input logic n);
      exp_t e;
      exp_cnt = exp_cnt + 1'b1;
      exp_q.push_back({n, exp_cnt});
      for (int i = 0; i < fw; i++) begin
         mem_ack = 1'b0; neg = 1'($urandom_range(0, 1)); #1;
         checks++; if (obs !== E_FETCH) begin errors++; $display("FAIL fetch_wait got=%b exp=%b", obs, E_FETCH); end
         @(negedge clk);
      end
      mem_ack = 1'b1; neg = 1'($urandom_range(0, 1)); #1;
      checks++; if (obs !== E_FETCH_ACK) begin errors++; $display("FAIL fetch_ack got=%b exp=%b", obs, E_FETCH_ACK); end
      @(negedge clk);
      for (int i = 0; i < rw; i++) begin
         mem_ack = 1'b0; neg = 1'($urandom_range(0, 1)); #1;
         checks++; if (obs !== E_READ) begin errors++; $display("FAIL read_wait got=%b exp=%b", obs, E_READ); end
         @(negedge clk);
      end
      mem_ack = 1'b1; neg = 1'($urandom_range(0, 1)); #1;
      checks++; if (obs !== E_READ_ACK) begin errors++; $display("FAIL read_ack got=%b exp=%b", obs, E_READ_ACK); end
      @(negedge clk);
      for (int i = 0; i <= ww; i++) begin
         mem_ack = (i == ww); neg = 1'($urandom_range(0, 1)); #1;
         checks++; if (obs !== E_WRITE) begin errors++; $display("FAIL write_state got=%b exp=%b", obs, E_WRITE); end
         @(negedge clk);
      end
      mem_ack = 1'b0; neg = n; #1;
      e = '0;
      checks++;
      if (exp_q.size() == 0) begin
         errors++; $display("FAIL scoreboard_empty got=0 entries exp=1");
      end else begin
         e = exp_q.pop_front();
         if (obs !== (E_UPDATE | {3'b000, e.sel, 7'b0000000})) begin
            errors++; $display("FAIL update_outputs got=%b exp=%b", obs, E_UPDATE | {3'b000, e.sel, 7'b0000000});
         end
      end
      @(negedge clk);
      neg = 1'b0;
      checks++; if (instr_count !== e.cnt) begin errors++; $display("FAIL instr_count got=%0d exp=%0d", instr_count, e.cnt); end
   endtask

   task automatic pulse_start(input logic [10:0] from_state);
      start = 1'b1; #1;
      checks++; if (obs !== from_state) begin errors++; $display("FAIL pre_start got=%b exp=%b", obs, from_state); end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; halt_req = 1'b0; step_mode = 1'b0; step = 1'b0;
      neg = 1'b0; mem_ack = 1'b1; exp_cnt = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", obs, E_IDLE); end
      checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
      @(negedge clk);
      rst = 1'b0; start = 1'b0; step = 1'b1; halt_req = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL idle_ignores got=%b exp=%b", obs, E_IDLE); end
      step = 1'b0; halt_req = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero_wait();
      pulse_start(E_IDLE);
      run_instr(0, 0, 0, 1'b0);
      run_instr(0, 0, 0, 1'b1);
      run_instr(0, 0, 0, 1'b1);
      #1;
      checks++; if (obs !== E_FETCH) begin errors++; $display("FAIL back_to_back got=%b exp=%b", obs, E_FETCH); end
   endtask

   task automatic test_halt_mid();
      halt_req = 1'b1;
      run_instr(1, 0, 0, 1'b0);
      halt_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step = 1'b1; mem_ack = 1'b1; #1;
         checks++; if (obs !== E_HALT) begin errors++; $display("FAIL halt_state got=%b exp=%b", obs, E_HALT); end
         checks++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL halt_count got=%0d exp=%0d", instr_count, exp_cnt); end
         @(negedge clk);
      end
      step = 1'b0; mem_ack = 1'b0;
      pulse_start(E_HALT);
      run_instr(0, 0, 0, 1'b1);
   endtask

   task automatic test_wait_states();
      run_instr(0, 3, 0, 1'b0);
      run_instr(15, 0, 2, 1'b1);
   endtask

   task automatic test_step();
      step_mode = 1'b1;
      run_instr(0, 0, 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         start = 1'b1; mem_ack = 1'b1; #1;
         checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL pause_state got=%b exp=%b", obs, E_IDLE); end
         checks++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL pause_count got=%0d exp=%0d", instr_count, exp_cnt); end
         @(negedge clk);
      end
      start = 1'b0; mem_ack = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step = 1'b1; #1;
         checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL pause_step got=%b exp=%b", obs, E_IDLE); end
         @(negedge clk);
         step = 1'b0;
         run_instr(0, 1, 0, 1'($urandom_range(0, 1)));
      end
      halt_req = 1'b1; step = 1'b1; #1;
      checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL pause_halt got=%b exp=%b", obs, E_IDLE); end
      @(negedge clk);
      halt_req = 1'b0; step = 1'b0; step_mode = 1'b0; #1;
      checks++; if (obs !== E_HALT) begin errors++; $display("FAIL step_halt got=%b exp=%b", obs, E_HALT); end
      checks++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL step_halt_count got=%0d exp=%0d", instr_count, exp_cnt); end
      @(negedge clk);
      pulse_start(E_HALT);
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 16; k++) begin
         run_instr($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_reset_mid();
      mem_ack = 1'b1;
      repeat (2) @(negedge clk);
      mem_ack = 1'b0; #1;
      checks++; if (obs !== E_WRITE) begin errors++; $display("FAIL pre_reset_write got=%b exp=%b", obs, E_WRITE); end
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL mid_reset_outputs got=%b exp=%b", obs, E_IDLE); end
         checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL mid_reset_count got=%0d exp=0", instr_count); end
      end
      rst = 1'b0; exp_cnt = '0; exp_q.delete();
      @(negedge clk); #1;
      checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL post_reset_idle got=%b exp=%b", obs, E_IDLE); end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      pulse_start(E_IDLE);
      mem_ack = 1'b1;
      repeat (2) @(negedge clk);
      mem_ack = 1'b0;
      for (int i = 0; i < 16; i++) begin
         #1;
         checks++; if (obs !== E_WRITE) begin errors++; $display("FAIL timeout_wait got=%b exp=%b cycle=%0d", obs, E_WRITE, i); end
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (obs !== E_ERROR) begin errors++; $display("FAIL timeout_error got=%b exp=%b", obs, E_ERROR); end
         start = 1'b1; mem_ack = 1'b1; step = 1'b1;
         @(negedge clk);
      end
      start = 1'b0; mem_ack = 1'b0; step = 1'b0;
      checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL timeout_count got=%0d exp=0", instr_count); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; #1;
      checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL error_cleared got=%b exp=%b", obs, E_IDLE); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_zero_wait();
      test_halt_mid();
      test_wait_states();
      test_step();
      test_wrap();
      test_reset_mid();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rssb_seq_control.md
Name: rssb_seq_control

Overview:
- Parametrised successor to the fixed four-state RSSB control FSM.
- Sequences the per-instruction phases against a memory that acknowledges each access:
  - fetch operand address (mem[pc]),
  - read mem[op1],
  - write result back,
  - update pc, with skip on borrow.
- Adds start/halt control, a single-step mode, a per-access timeout with a sticky error, and a retired-instruction counter.
- Sits between the datapath (op1/acc/pc registers, subtractor, pc mux, memory address mux) and the memory port.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles waiting for mem_ack per access. 0 disables the timeout.
- CNT_W, 16: width of instr_count.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  leave IDLE or HALT and begin fetching; sampled only in those states.
- halt_req  input  1  stop at the next instruction boundary.
- step_mode  input  1  when 1, pause after every instruction.
- step  input  1  in PAUSE, run exactly one more instruction.
- neg  input  1  datapath borrow flag (result negative); sampled in UPDATE.
- mem_ack  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access request; held until mem_ack.
- mem_we  output  1  1 = write access, 0 = read.
- sel_mem  output  1  memory address select: 0 = pc, 1 = op1.
- sel_pc  output  1  pc mux: 0 = pc+1, 1 = pc+2 (skip).
- write_op1  output  1  load op1 from memory read data.
- write_acc  output  1  load acc with mem_rdata - acc.
- write_mem  output  1  drive acc onto memory write data.
- write_pc  output  1  load pc from the pc mux.
- busy  output  1  1 in FETCH, READ, WRITE, UPDATE.
- halted  output  1  1 in HALT.
- error  output  1  1 in ERROR (sticky).
- instr_count  output  CNT_W  retired instructions.

Behaviour:
- States: IDLE, FETCH, READ, WRITE, UPDATE, PAUSE, HALT, ERROR.
- Reset (rst=1 at a clock edge, any state, including mid-access):
  - state goes to IDLE and instr_count goes to 0.
  - All outputs are 0 after reset; with rst held high they stay 0.
  - An outstanding mem_req is dropped and no ack is awaited.
- Outputs are Moore-decoded from state unless noted. Unlisted outputs are 0 in each state.
- IDLE: all outputs 0. start=1 -> FETCH.
- FETCH: mem_req=1, mem_we=0, sel_mem=0.
  - On mem_ack: write_op1=1 (Mealy, same cycle) -> READ.
- READ: mem_req=1, mem_we=0, sel_mem=1.
  - On mem_ack: write_acc=1 (Mealy) -> WRITE.
- WRITE: mem_req=1, mem_we=1, sel_mem=1, write_mem=1 for the whole state.
  - On mem_ack -> UPDATE.
- UPDATE (exactly one cycle):
  - write_pc=1, sel_pc=neg.
  - instr_count increments, wrapping from all-ones to 0.
  - Next-state priority: halt_req=1 -> HALT; else step_mode=1 -> PAUSE; else -> FETCH.
- PAUSE: all strobes 0.
  - step=1 -> FETCH; one instruction then runs and returns to PAUSE if step_mode is still 1.
  - halt_req=1 -> HALT, with priority over step.
- HALT: halted=1.
  - start=1 -> FETCH; pc and instr_count are preserved.
- ERROR: error=1, all other outputs 0. Exit only via rst.
- Timeout, active when TIMEOUT_CYCLES > 0:
  - Wait counter clears on entry to each of FETCH, READ, WRITE.
  - It increments each cycle in those states without mem_ack.
  - When it reaches TIMEOUT_CYCLES and mem_ack=0 -> ERROR.
  - An ack on the same cycle the count reaches the limit wins, and the access completes normally.
- Minimum instruction latency with zero-wait memory (mem_ack=1 every cycle): 4 cycles (FETCH, READ, WRITE, UPDATE).
- halt_req asserted mid-instruction does not abort it. It takes effect only at UPDATE or in PAUSE.
- start outside IDLE/HALT, step outside PAUSE, and mem_ack outside access states are all ignored.

Test Plan:
- Reset, then start pulse with mem_ack tied 1 -> FETCH/READ/WRITE/UPDATE repeating every 4 cycles. write_op1, write_acc, write_pc each pulse once per instruction. instr_count = 3 after 12 cycles.
- neg=1 in UPDATE -> sel_pc=1 with write_pc=1. neg=0 -> sel_pc=0. neg toggled in other states has no effect on outputs.
- mem_ack delayed 3 cycles in READ, TIMEOUT_CYCLES=16 -> mem_req/sel_mem=1 held 4 cycles, write_acc pulses once on the ack cycle, no error. Ack withheld 16 cycles in WRITE -> error=1 and mem_req=0 next cycle, both held until rst.
- step_mode=1 -> PAUSE after each UPDATE. Each step pulse increments instr_count by exactly 1. halt_req=1 together with step in PAUSE -> HALT, halted=1, instr_count unchanged.
- halt_req raised during FETCH -> current instruction completes, HALT entered after its UPDATE. start then resumes at FETCH with instr_count continuing from its held value.
- rst asserted in WRITE with mem_req high -> next cycle IDLE, all outputs 0, instr_count=0. instr_count with CNT_W=4 wraps 15 -> 0 on the 16th instruction.
